// File: rtl/latch_strobe_gen.sv
// latch_strobe_gen: serializes a parallel word LSB first onto a D-latch
// interface. Each bit gets one setup cycle with e low, EN_HIGH cycles of
// e high and EN_LOW hold cycles with e low, so d is always stable around
// the enable strobe. All outputs come straight from flops.
//
// Optional feature: define STROBE_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after the WIDTH data bits.
module latch_strobe_gen #(
    parameter int WIDTH   = 8,
    parameter int EN_HIGH = 2,
    parameter int EN_LOW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d,
    output logic             e,
    output logic             busy,
    output logic             done
);

`ifdef STROBE_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam int PH_MAX = (EN_HIGH > EN_LOW) ? EN_HIGH : EN_LOW;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BC_W   = $clog2(NBITS + 1);

    localparam logic [PH_W-1:0] PH_HI_LAST = PH_W'(EN_HIGH - 1);
    localparam logic [PH_W-1:0] PH_LO_LAST = PH_W'(EN_LOW - 1);
    localparam logic [BC_W-1:0] BC_LAST    = BC_W'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [NBITS-1:0]  shift_q, shift_d;
    logic              d_q, d_d;
    logic              e_q, e_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [NBITS-1:0]  word_full;

    // Word as it will go out on the wire, parity bit on top when enabled.
`ifdef STROBE_PARITY_EN
    assign word_full = {^in_data, in_data};
`else
    assign word_full = in_data;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        d_d       = d_q;

        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    state_d   = SETUP;
                    d_d       = in_data[0];
                    shift_d   = word_full >> 1;
                    bit_cnt_d = '0;
                    phase_d   = '0;
                end
            end
            SETUP: begin
                state_d = STROBE;
                phase_d = '0;
            end
            STROBE: begin
                if (phase_q == PH_HI_LAST) begin
                    state_d = HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            HOLD: begin
                if (phase_q == PH_LO_LAST) begin
                    phase_d = '0;
                    if (bit_cnt_q == BC_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d   = SETUP;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        d_d       = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // NOTE: outputs are decoded from the next state and then registered,
        // so they change on the same edge as the state with no input-to-output
        // combinational path and no decode glitches on e.
        e_d     = (state_d == STROBE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    // State, counters, shift register and output flops; reset aborts a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            shift_q   <= '0;
            d_q       <= 1'b0;
            e_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            d_q       <= d_d;
            e_q       <= e_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign d        = d_q;
    assign e        = e_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = ready_q;

endmodule

// File: doc/latch_strobe_gen.md
LATCH_STROBE_GEN -- requirements
Module: latch_strobe_gen

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 1..32.
REQ-002 Parameter EN_HIGH, default 2: e high time per bit, in clk cycles; legal range 1 or more.
REQ-003 Parameter EN_LOW, default 3: e low hold time per bit after the strobe, in clk cycles; legal range 1 or more.
REQ-004 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in_data, input, WIDTH: parallel word to be serialized.
REQ-007 Port in_valid, input, 1: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1: block can accept a word this cycle.
REQ-009 Port d, output, 1: serial data bit to the downstream D latch.
REQ-010 Port e, output, 1: latch enable strobe to the downstream D latch.
REQ-011 Port busy, output, 1: high while a word is being sent.
REQ-012 Port done, output, 1: one-cycle pulse when a word has finished.

Function
REQ-013 The block SHALL be an FSM with states IDLE, SETUP, STROBE, HOLD and DONE, plus a bit counter and a phase counter.
REQ-014 A word SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; in_data is captured into a shift register and the FSM moves IDLE->SETUP.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored and SHALL NOT be queued.
REQ-016 Bits SHALL be sent LSB first; d SHALL change only on entry to SETUP and SHALL stay stable through SETUP, STROBE and HOLD of that bit.
REQ-017 SETUP SHALL last 1 cycle with e=0, STROBE SHALL last EN_HIGH cycles with e=1, and HOLD SHALL last EN_LOW cycles with e=0.
REQ-018 Each bit period SHALL therefore be 1+EN_HIGH+EN_LOW cycles, so d is stable at least 1 cycle before e rises and EN_LOW cycles after e falls.
REQ-019 After HOLD of a non-final bit, the FSM SHALL go to SETUP for the next bit; after HOLD of the final bit, it SHALL go to DONE.
REQ-020 DONE SHALL last exactly 1 cycle with done=1, e=0 and d held; the FSM then returns to IDLE.
REQ-021 A word presented during DONE SHALL NOT be accepted; it is accepted no earlier than the first IDLE cycle.
REQ-022 d, e, busy, done and in_ready SHALL all be registered outputs with no combinational path from any input; e SHALL be glitch-free.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 In IDLE, e SHALL be 0 and d SHALL hold its last driven value.

Reset
REQ-025 When reset is asserted, all outputs SHALL go immediately, without waiting for clk, to: state=IDLE, d=0, e=0, busy=0, done=0, in_ready=1, counters=0, shift register=0.
REQ-026 Reset asserted mid-word SHALL abort the transfer, discard the remaining bits and force e low at once; no done pulse SHALL be issued.
REQ-027 The block SHALL be ready to accept a word on the first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro STROBE_PARITY_EN defined: after the WIDTH data bits, the block SHALL send one extra bit with the same SETUP/STROBE/HOLD timing; that bit is the even-parity bit (XOR of the captured word), and done follows that bit's HOLD.
REQ-029 Macro STROBE_PARITY_EN undefined: exactly WIDTH bits SHALL be sent, and no parity logic SHALL be present.

Verification
REQ-030 Defaults, in_data=8'hA5 accepted at edge T: d sequence SHALL be 1,0,1,0,0,1,0,1; e SHALL be high 2 cycles in every 6-cycle period; done=1 exactly at T+49; in_ready=1 again at T+50.
REQ-031 STROBE_PARITY_EN defined, in_data=8'h07: 9 bits SHALL be sent with final bit 1; done=1 at T+55.
REQ-032 reset asserted during the STROBE of bit 3: e and d SHALL fall to 0 before the next clk edge; busy=0; no done pulse; a new word 8'h01 SHALL then send correctly.
REQ-033 in_valid held high continuously with 8'hFF then 8'h00: the second word SHALL be accepted only at the first IDLE cycle after done, never during DONE or busy.
REQ-034 EN_HIGH=1, EN_LOW=1, WIDTH=1, in_data=1: d=1 on the SETUP cycle, e=1 for one cycle, done on the 4th cycle after acceptance.
REQ-035 Over all scenarios, d SHALL never change while e=1 or in the cycle after e falls.
